somador_serial: RTL and testbench

Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in using one full-adder slice and a carry flip-flop, one bit per clock, LSB first. It sits between board keys or switches and the display and result logic, and replaces the purely combinational single-bit full adder. New capabilities:
- arbitrary operand width;
- a start/busy/done handshake;
- a signed-overflow flag;
- selectable input polarity for active-low push buttons.

---
 rtl/somador_serial.sv | 116 +++++++++++
 tb/tb_somador_serial.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/somador_serial.sv
// somador_serial: bit-serial adder, one full-adder slice plus carry flip-flop, LSB first.
// Latency: result and done appear WIDTH cycles after start is sampled; one add per WIDTH+2 cycles.
// Backpressure: none; start is ignored while busy or done, never queued.
module somador_serial #(
  parameter int WIDTH     = 8,
  parameter bit INVERT_IN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  localparam int               CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
  // Push buttons read 1 when released, so the whole operand set may be flipped at capture
  localparam logic [WIDTH-1:0] INV_MASK = {WIDTH{INVERT_IN}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic             w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_res_next;

  // Single full-adder slice working on the current LSBs
  assign w_sum      = r_a[0] ^ r_b[0] ^ r_c;
  assign w_carry    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

  // Control FSM, datapath shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a ^ INV_MASK;
            r_b     <= b ^ INV_MASK;
            r_c     <= cin ^ INVERT_IN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_carry;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            // During the final bit r_c is the carry into the MSB; XOR with the
            // carry out of the MSB gives signed overflow
            r_s     <= w_res_next;
            r_cout  <= w_carry;
            r_ovf   <= r_c ^ w_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign s        = r_s;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_somador_serial.sv
// Testbench for somador_serial: three instances (8-bit plain, 8-bit inverted, 2-bit plain)
// checked against an arithmetic reference model with directed, random and exhaustive stimulus.
module tb_somador_serial;

  logic clk;
  logic rst_n;

  // 8-bit, INVERT_IN=0
  logic       st0, cin0, busy0, done0, cout0, ovf0;
  logic [7:0] a0, b0, s0;
  // 8-bit, INVERT_IN=1
  logic       st1, cin1, busy1, done1, cout1, ovf1;
  logic [7:0] a1, b1, s1;
  // 2-bit, INVERT_IN=0
  logic       st2, cin2, busy2, done2, cout2, ovf2;
  logic [1:0] a2, b2, s2;

  int n_cmp;
  int n_bad;
  int sel;

  logic       m_busy, m_done, m_cout, m_ovf;
  logic [7:0] m_s;

  somador_serial #(.WIDTH(8), .INVERT_IN(1'b0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0), .cin(cin0),
    .busy(busy0), .done(done0), .s(s0), .cout(cout0), .overflow(ovf0));

  somador_serial #(.WIDTH(8), .INVERT_IN(1'b1)) u_w8_inv (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .overflow(ovf1));

  somador_serial #(.WIDTH(2), .INVERT_IN(1'b0)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .s(s2), .cout(cout2), .overflow(ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe the instance currently under test
  always_comb begin
    m_busy = busy0; m_done = done0; m_s = s0; m_cout = cout0; m_ovf = ovf0;
    case (sel)
      1: begin m_busy = busy1; m_done = done1; m_s = s1; m_cout = cout1; m_ovf = ovf1; end
      2: begin m_busy = busy2; m_done = done2; m_s = {6'd0, s2}; m_cout = cout2; m_ovf = ovf2; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int sl, input logic st, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic);
    case (sl)
      1: begin st1 = st; a1 = ia; b1 = ib; cin1 = ic; end
      2: begin st2 = st; a2 = ia[1:0]; b2 = ib[1:0]; cin2 = ic; end
      default: begin st0 = st; a0 = ia; b0 = ib; cin0 = ic; end
    endcase
  endtask

  // Reference: plain integer addition of the effective operands; returns {ovf, cout, s[7:0]}
  function automatic logic [9:0] ref_add(input int w, input bit inv, input logic [7:0] ia,
                                         input logic [7:0] ib, input logic ic);
    int mask, ae, be, ce, sum, sv, co, ov;
    mask = (1 << w) - 1;
    ae   = (inv ? ~int'(ia) : int'(ia)) & mask;
    be   = (inv ? ~int'(ib) : int'(ib)) & mask;
    ce   = inv ? int'(!ic) : int'(ic);
    sum  = ae + be + ce;
    sv   = sum & mask;
    co   = (sum >> w) & 1;
    ov   = (((ae >> (w - 1)) & 1) == ((be >> (w - 1)) & 1)) &&
           (((sv >> (w - 1)) & 1) != ((ae >> (w - 1)) & 1)) ? 1 : 0;
    return {ov[0], co[0], sv[7:0]};
  endfunction

  // One add: start for one cycle, count busy cycles and done pulses over a bounded window.
  // disturb: pulse start again mid-run and change the operand buses.
  task automatic do_op(input int sl, input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input bit disturb, input string tag);
    int w, nbusy, ndone, first_done;
    logic [9:0] exp_r;
    w     = (sl == 2) ? 2 : 8;
    exp_r = ref_add(w, sl == 1, ia, ib, ic);
    sel   = sl;
    @(negedge clk);
    set_in(sl, 1'b1, ia, ib, ic);
    @(negedge clk);
    set_in(sl, 1'b0, ia, ib, ic);
    nbusy = 0; ndone = 0; first_done = -1;
    for (int k = 1; k <= 20; k++) begin
      if (m_busy) nbusy++;
      if (m_done) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
      if (disturb && k == 3) set_in(sl, 1'b1, ~ia, ~ib, ~ic);
      if (disturb && k == 4) set_in(sl, 1'b0, ~ia, ~ib, ~ic);
      @(negedge clk);
    end
    chk({tag, "_s"},     m_s,    exp_r[7:0]);
    chk({tag, "_cout"},  m_cout, exp_r[8]);
    chk({tag, "_ovf"},   m_ovf,  exp_r[9]);
    chk({tag, "_busy"},  nbusy,  w);
    chk({tag, "_ndone"}, ndone,  1);
    chk({tag, "_tdone"}, first_done, w + 1);
  endtask

  initial begin
    int d1, d2, nd;
    logic [7:0] ra, rb;
    logic rc;
    n_cmp = 0; n_bad = 0; sel = 0;
    rst_n = 1'b0;
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_in(1, 1'b0, 8'hFF, 8'hFF, 1'b1);
    set_in(2, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_w8",  {busy0, done0, s0, cout0, ovf0}, 0);
    chk("rst_inv", {busy1, done1, s1, cout1, ovf1}, 0);
    chk("rst_w2",  {busy2, done2, s2, cout2, ovf2}, 0);
    rst_n = 1'b1;

    // Directed cases
    do_op(0, 8'h3C, 8'h0F, 1'b0, 1'b0, "add_3c_0f");
    chk("dir_4b", m_s, 8'h4B);
    do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    chk("dir_cout", {m_cout, m_s}, 9'h100);
    do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, "add_7f_01");
    chk("dir_ovf", {m_ovf, m_cout, m_s}, 10'h280);
    do_op(1, 8'hFE, 8'hFD, 1'b1, 1'b0, "inv_fe_fd");
    chk("dir_inv", {m_cout, m_s}, 9'h003);
    do_op(0, 8'h55, 8'h21, 1'b1, 1'b1, "disturb");

    // start held high: re-trigger every IDLE visit, done pulses WIDTH+2 apart
    sel = 0;
    @(negedge clk);
    set_in(0, 1'b1, 8'h12, 8'h34, 1'b0);
    d1 = -1; d2 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done0) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
    end
    set_in(0, 1'b0, 8'h12, 8'h34, 1'b0);
    chk("held_seen", (d1 >= 0) && (d2 >= 0), 1);
    chk("held_gap", d2 - d1, 10);
    chk("held_s", s0, 8'h46);
    repeat (12) @(negedge clk);

    // Reset between edges 4 and 5 aborts the add and clears outputs
    set_in(0, 1'b1, 8'hA5, 8'h11, 1'b0);
    @(negedge clk);
    set_in(0, 1'b0, 8'hA5, 8'h11, 1'b0);
    repeat (4) @(negedge clk);
    chk("mid_busy_pre", busy0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_s", s0, 0);
    chk("mid_rst_flags", {done0, cout0, ovf0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done0 || busy0) nd++;
    end
    chk("mid_no_done", nd, 0);
    do_op(0, 8'h10, 8'h20, 1'b0, 1'b0, "after_rst");
    chk("after_rst_30", m_s, 8'h30);

    // Random stimulus on both 8-bit instances
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      do_op(0, ra, rb, rc, i[2:0] == 3'd5, $sformatf("rnd8_%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      do_op(1, ra, rb, rc, 1'b0, $sformatf("rndinv_%0d", i));
    end

    // Exhaustive 2-bit instance
    for (int i = 0; i < 32; i++) begin
      do_op(2, {6'd0, 2'(i >> 3)}, {6'd0, 2'(i >> 1)}, 1'(i), 1'b0, $sformatf("w2_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
